// File: rtl/ami_pkg.sv
// Shared AMI line definitions: symbol classes, polarity FSM states, rail encodings.
package ami_pkg;

    // Rail encodings as {p, n}; the transmit side drives the same constants
    localparam logic [1:0] RAIL_SPACE   = 2'b00;
    localparam logic [1:0] RAIL_POS     = 2'b10;
    localparam logic [1:0] RAIL_NEG     = 2'b01;
    localparam logic [1:0] RAIL_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        SPACE   = RAIL_SPACE,
        POS     = RAIL_POS,
        NEG     = RAIL_NEG,
        ILLEGAL = RAIL_ILLEGAL
    } sym_t;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        LAST_POS = 2'd1,
        LAST_NEG = 2'd2
    } pol_t;

    function automatic sym_t classify(input logic p, input logic n);
        return sym_t'({p, n});
    endfunction

endpackage

// File: rtl/ami_decoder_if.sv
// Line-side strobe/rails in, decoded stream and status out.
interface ami_decoder_if #(
    parameter int CNT_W = 8
);
    logic             sym_en;
    logic             p_in;
    logic             n_in;
    logic             clr_cnt;
    logic             dout;
    logic             dout_vld;
    logic [7:0]       byte_out;
    logic             byte_vld;
    logic             bpv;
    logic             rail_err;
    logic             los;
    logic [CNT_W-1:0] bpv_cnt;

    modport master (
        output sym_en, p_in, n_in, clr_cnt,
        input  dout, dout_vld, byte_out, byte_vld, bpv, rail_err, los, bpv_cnt
    );

    modport slave (
        input  sym_en, p_in, n_in, clr_cnt,
        output dout, dout_vld, byte_out, byte_vld, bpv, rail_err, los, bpv_cnt
    );
endinterface

// File: rtl/ami_deser8.sv
// 8-bit LSB-first deserializer with bit index, byte-valid pulse and flush.
module ami_deser8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift_en,
    input  logic       bit_in,
    input  logic       flush,
    output logic [7:0] byte_out,
    output logic       byte_vld
);
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] byte_q, byte_d;
    logic       byte_vld_q, byte_vld_d;

    // Next-state: flush discards the partial byte (and the bit arriving with it)
    always_comb begin
        shreg_d    = shreg_q;
        idx_d      = idx_q;
        byte_d     = byte_q;
        byte_vld_d = 1'b0;
        if (flush) begin
            shreg_d = '0;
            idx_d   = '0;
        end else if (shift_en) begin
            shreg_d = {bit_in, shreg_q[7:1]};
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
                byte_d     = {bit_in, shreg_q[7:1]};
                byte_vld_d = 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q    <= '0;
            idx_q      <= '0;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            idx_q      <= idx_d;
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
        end
    end

    assign byte_out = byte_q;
    assign byte_vld = byte_vld_q;
endmodule

// File: rtl/ami_decoder.sv
// AMI two-rail receive decoder: classifier, polarity/BPV FSM, LOS detection, BPV counter.
module ami_decoder
    import ami_pkg::*;
#(
    parameter int LOS_ZEROS = 15,
    parameter int CNT_W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    ami_decoder_if.slave  bus
);
    localparam logic [7:0] LOS_MAX = 8'(LOS_ZEROS);

    sym_t             sym;
    logic             is_mark, is_space, is_ill, los_rise;
    pol_t             pol_q, pol_d;
    logic [7:0]       zcnt_q, zcnt_d;
    logic             los_q, los_d;
    logic             dout_q, dout_d;
    logic             dout_vld_q, dout_vld_d;
    logic             bpv_q, bpv_d;
    logic             rail_err_q, rail_err_d;
    logic [CNT_W-1:0] bpv_cnt_q, bpv_cnt_d;

    assign sym = classify(bus.p_in, bus.n_in);

    // Symbol classification and all next-state logic for the decoder core
    always_comb begin
        is_mark  = 1'b0;
        is_space = 1'b0;
        is_ill   = 1'b0;
        if (bus.sym_en) begin
            unique case (sym)
                POS, NEG: is_mark  = 1'b1;
                SPACE:    is_space = 1'b1;
                default:  is_ill   = 1'b1;
            endcase
        end

        zcnt_d = zcnt_q;
        if (is_space && zcnt_q != LOS_MAX) zcnt_d = zcnt_q + 8'd1;
        else if (is_mark || is_ill)        zcnt_d = '0;

        los_d = los_q;
        if (is_space && zcnt_d == LOS_MAX) los_d = 1'b1;
        else if (is_mark)                  los_d = 1'b0;
        los_rise = los_d & ~los_q;

        bpv_d = is_mark && ((sym == POS && pol_q == LAST_POS) ||
                            (sym == NEG && pol_q == LAST_NEG));

        pol_d = pol_q;
        if (los_rise)     pol_d = NONE;
        else if (is_mark) pol_d = (sym == POS) ? LAST_POS : LAST_NEG;

        dout_d     = bus.sym_en ? is_mark : dout_q;
        dout_vld_d = bus.sym_en;
        rail_err_d = is_ill;

        bpv_cnt_d = bpv_cnt_q;
        if (bus.clr_cnt)                bpv_cnt_d = bpv_d ? CNT_W'(1) : '0;
        else if (bpv_d && bpv_cnt_q != '1) bpv_cnt_d = bpv_cnt_q + CNT_W'(1);
    end

    // Decoder core registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pol_q      <= NONE;
            zcnt_q     <= '0;
            los_q      <= 1'b0;
            dout_q     <= 1'b0;
            dout_vld_q <= 1'b0;
            bpv_q      <= 1'b0;
            rail_err_q <= 1'b0;
            bpv_cnt_q  <= '0;
        end else begin
            pol_q      <= pol_d;
            zcnt_q     <= zcnt_d;
            los_q      <= los_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            bpv_q      <= bpv_d;
            rail_err_q <= rail_err_d;
            bpv_cnt_q  <= bpv_cnt_d;
        end
    end

    ami_deser8 u_deser (
        .clk      (clk),
        .rst      (rst),
        .shift_en (bus.sym_en),
        .bit_in   (is_mark),
        .flush    (los_rise),
        .byte_out (bus.byte_out),
        .byte_vld (bus.byte_vld)
    );

    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;
    assign bus.bpv      = bpv_q;
    assign bus.rail_err = rail_err_q;
    assign bus.los      = los_q;
    assign bus.bpv_cnt  = bpv_cnt_q;
endmodule

// File: tb/tb_ami_decoder.sv
// Scoreboard bench for ami_decoder: behavioural model pushes expectations, monitor pops and compares.
module tb_ami_decoder;
    localparam int LOS = 15;

    typedef struct {
        logic       dout;
        logic       dout_vld;
        logic       byte_vld;
        logic [7:0] byte_out;
        logic       bpv;
        logic       rail_err;
        logic       los;
        logic [7:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   seq = 0;
    exp_t sb[$];

    // reference model state
    int         m_pol;
    int         m_zrun;
    bit         m_los;
    int         m_cnt;
    logic [7:0] m_bits;
    logic [7:0] m_byte;
    int         m_idx;
    bit         m_dout;

    ami_decoder_if #(.CNT_W(8)) bus ();

    ami_decoder #(.LOS_ZEROS(LOS), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pol = 0; m_zrun = 0; m_los = 0; m_cnt = 0;
        m_bits = '0; m_byte = '0; m_idx = 0; m_dout = 0;
    endtask

    // Drive one cycle of inputs and queue the outputs expected on the next edge
    task automatic put_sym(input bit en, input bit p, input bit n, input bit clr);
        exp_t e;
        bit mark, space, ill, bpv, rise, d;
        @(negedge clk);
        bus.sym_en = en; bus.p_in = p; bus.n_in = n; bus.clr_cnt = clr;
        mark  = en && (p != n);
        space = en && !p && !n;
        ill   = en && p && n;
        d     = mark;
        bpv   = mark && ((p && m_pol == 1) || (n && m_pol == 2));
        rise  = 0;
        if (mark) m_pol = p ? 1 : 2;
        if (space) begin
            if (m_zrun < LOS) m_zrun++;
            if (m_zrun == LOS && !m_los) begin rise = 1; m_los = 1; end
        end
        if (mark || ill) m_zrun = 0;
        if (mark) m_los = 0;
        if (rise) m_pol = 0;
        if (clr) m_cnt = bpv ? 1 : 0;
        else if (bpv && m_cnt < 255) m_cnt++;
        e.byte_vld = 0;
        if (rise) begin
            m_idx = 0; m_bits = '0;
        end else if (en) begin
            m_bits[m_idx] = d;
            if (m_idx == 7) begin m_byte = m_bits; e.byte_vld = 1; m_idx = 0; end
            else m_idx++;
        end
        if (en) m_dout = d;
        e.dout = m_dout; e.dout_vld = en; e.byte_out = m_byte; e.bpv = bpv;
        e.rail_err = ill; e.los = m_los; e.cnt = 8'(m_cnt);
        sb.push_back(e);
    endtask

    // rails: 1 = +, -1 = -, 0 = space, 2 = illegal
    task automatic put_rail(input int r);
        put_sym(1, r == 1 || r == 2, r == -1 || r == 2, 0);
    endtask

    task automatic drain();
        put_sym(0, 0, 0, 0);
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk); #2;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"}, bus.dout, 0);
        check({tag, "_dout_vld"}, bus.dout_vld, 0);
        check({tag, "_byte_out"}, bus.byte_out, 0);
        check({tag, "_byte_vld"}, bus.byte_vld, 0);
        check({tag, "_bpv"}, bus.bpv, 0);
        check({tag, "_rail_err"}, bus.rail_err, 0);
        check({tag, "_los"}, bus.los, 0);
        check({tag, "_bpv_cnt"}, bus.bpv_cnt, 0);
    endtask

    // Monitor: compare each registered output set against the scoreboard head
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0 && !rst) begin
            e = sb.pop_front();
            seq++;
            check($sformatf("dout@%0d", seq), bus.dout, e.dout);
            check($sformatf("dout_vld@%0d", seq), bus.dout_vld, e.dout_vld);
            check($sformatf("byte_vld@%0d", seq), bus.byte_vld, e.byte_vld);
            check($sformatf("byte_out@%0d", seq), bus.byte_out, e.byte_out);
            check($sformatf("bpv@%0d", seq), bus.bpv, e.bpv);
            check($sformatf("rail_err@%0d", seq), bus.rail_err, e.rail_err);
            check($sformatf("los@%0d", seq), bus.los, e.los);
            check($sformatf("bpv_cnt@%0d", seq), bus.bpv_cnt, e.cnt);
        end
    end

    initial begin
        int pat[8];
        rst = 1'b1;
        bus.sym_en = 0; bus.p_in = 0; bus.n_in = 0; bus.clr_cnt = 0;
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // 0xA5 byte
        pat = '{1, 0, -1, 0, 0, 1, 0, -1};
        foreach (pat[i]) put_rail(pat[i]);
        // + 0 + -> bpv, then - legal
        put_rail(1); put_rail(0); put_rail(1); put_rail(-1);
        drain();

        // LOS after 15 spaces, then a + restarts a byte
        for (int i = 0; i < LOS; i++) put_rail(0);
        put_rail(1);
        for (int i = 0; i < 7; i++) put_rail(i % 2 == 0 ? 0 : -1);
        drain();

        // illegal keeps polarity: + 11 + -> bpv; 11 then - legal
        put_rail(1); put_rail(2); put_rail(1); put_rail(2); put_rail(-1);
        drain();

        // gapped strobes, random rails, occasional clr_cnt
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            put_sym($urandom_range(0, 2) != 0, r == 1 || r == 3 || r == 9,
                    r == 2 || r == 3 || r == 8, $urandom_range(0, 20) == 0);
        end
        drain();

        // saturate counter, then clear coincident with a bpv
        for (int i = 0; i < 301; i++) put_rail(1);
        put_sym(1, 1, 0, 1);
        put_sym(0, 0, 0, 1);
        drain();

        // async reset after 5 bits, then a full byte
        pat = '{1, 1, 0, 1, 0, 0, 0, 0};
        for (int i = 0; i < 5; i++) put_rail(-1);
        drain();
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        pat = '{1, 0, -1, 0, 1, 1, 0, 0};
        foreach (pat[i]) put_rail(pat[i]);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ami_decoder.md
# ami_decoder

Receive-side line decoder for the team's AMI (alternate mark inversion) two-rail link. It samples the positive and negative rails once per symbol strobe and recovers the data bit. It also flags bipolar violations and illegal rail combinations, and declares loss-of-signal after a run of spaces. Recovered bits are deserialized into bytes for the downstream framer.

## Interface
Parameters:
- LOS_ZEROS, 15: number of consecutive space symbols that asserts `los` (legal range 2..255).
- CNT_W, 8: width of the bipolar-violation counter.

Ports:
- clk  in  1  single system clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all state.
- sym_en  in  1  symbol strobe; the rails are sampled only when this is 1.
- p_in  in  1  positive rail (mark +).
- n_in  in  1  negative rail (mark −).
- clr_cnt  in  1  synchronous clear of `bpv_cnt`.
- dout  out  1  decoded data bit.
- dout_vld  out  1  one-cycle pulse; `dout` is valid.
- byte_out  out  8  assembled byte, LSB received first.
- byte_vld  out  1  one-cycle pulse; `byte_out` is valid.
- bpv  out  1  one-cycle pulse on a bipolar violation.
- rail_err  out  1  one-cycle pulse when both rails are high.
- los  out  1  level; loss-of-signal is active.
- bpv_cnt  out  CNT_W  saturating count of bipolar violations.

## Operation
- Symbol classification on each `sym_en`:
  - {p,n}=10 → POS.
  - 01 → NEG.
  - 00 → SPACE.
  - 11 → ILLEGAL.
- Decoding:
  - POS and NEG decode to 1.
  - SPACE and ILLEGAL decode to 0.
  - Every symbol, including ILLEGAL, produces a `dout_vld` pulse and a deserializer shift.
- Polarity FSM, states NONE, LAST_POS, LAST_NEG:
  - POS moves to LAST_POS; NEG moves to LAST_NEG.
  - A mark with the same polarity as the current LAST_x state pulses `bpv`; the state remains LAST_x.
  - From NONE, any mark is legal and does not pulse `bpv`.
  - SPACE and ILLEGAL leave the state unchanged.
  - When `los` asserts, the FSM is forced to NONE.
- ILLEGAL symbol: pulses `rail_err`, leaves the polarity state unchanged, and resets the zero-run counter.
- Zero-run counter:
  - Increments on SPACE and saturates at LOS_ZEROS.
  - Cleared by any mark or ILLEGAL symbol.
  - `los` asserts in the same cycle the count reaches LOS_ZEROS.
  - `los` deasserts on the first following mark.
- `bpv_cnt`:
  - Increments on each `bpv` and saturates at 2^CNT_W−1.
  - If `clr_cnt` and `bpv` occur in the same cycle, the result is 1.
  - If `clr_cnt` occurs alone, the result is 0.
- Deserializer:
  - Shifts `dout` in LSB-first with a 3-bit index.
  - `byte_vld` pulses on the 8th bit; the index then wraps to 0.
  - On the `los` rising edge, the index clears and the partial byte is discarded. No `byte_vld` is issued for it.
  - The `byte_out` register holds its value between pulses.

## Timing
- All outputs are registered.
- `dout`, `dout_vld`, `bpv`, `rail_err`, and the `los` update appear on the clock edge after the sampling edge. Latency is 1 clk from the `sym_en`-qualified sample.
- `byte_vld` is coincident with the `dout_vld` of the 8th bit.
- `bpv_cnt` reflects a violation in the same cycle as its `bpv` pulse.
- `sym_en` may be held high every cycle (one symbol per clk) or gapped arbitrarily. Pulse outputs are 0 in cycles without a preceding strobe.
- Reset values:
  - `dout`, `dout_vld`, `byte_vld`, `bpv`, `rail_err`, `los`, `bpv_cnt`, and `byte_out` are all 0.
  - Polarity FSM = NONE; zero-run counter = 0; bit index = 0.
- Reset asserted mid-byte: the partial byte is lost, and the first bit after release is bit 0.

## Structure
- Package `ami_pkg`:
  - `sym_t` enum: SPACE, POS, NEG, ILLEGAL.
  - `pol_t` enum: NONE, LAST_POS, LAST_NEG.
  - Rail-encoding constants shared with the transmit side.
- Sub-module `ami_deser8`: 8-bit LSB-first shift register with index, byte valid, and synchronous flush input (driven by the `los` rise).
- Top level contains the classifier, polarity FSM, zero-run counter, LOS logic and BPV counter.

## Test plan
- Rails +,0,−,0,0,+,0,− with `sym_en` every clk → bits 1,0,1,0,0,1,0,1 → `byte_vld` once with `byte_out`=0xA5; `bpv`=0, `rail_err`=0.
- Rails +,0,+ → `bpv` pulse on the 3rd symbol, `bpv_cnt`=1, `dout`=1; a following − is legal (no `bpv`).
- 15 consecutive 00 symbols with LOS_ZEROS=15 → `los` rises on the 15th; the partial byte is flushed; next symbol + → `los`=0, no `bpv`, and that bit is bit 0 of a new byte.
- Rails 11 → `rail_err` pulse, `dout`=0; the following mark's BPV check uses the polarity from before the 11.
- Force 300 violations with CNT_W=8 → `bpv_cnt` holds 255; `clr_cnt` coincident with a `bpv` → `bpv_cnt`=1.
- Assert `rst` asynchronously after 5 bits of a byte → all outputs 0 immediately; 8 further bits → `byte_vld` with exactly those 8 bits.
